trng_ctrl: RTL and testbench

Controller that sequences the ring-oscillator TRNG macro: enables it, waits a warm-up period and samples its single-bit output at a programmable rate. It packs the sampled bits into words and runs a repetition-count health test on the bit stream. Finished words go to the SoC peripheral bus through a valid/ready handshake. It sits between the TRNG macro (drives trng_en, consumes trng_out) and the bus register interface.

---
 rtl/trng_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_trng_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/trng_ctrl.sv
// trng_ctrl: sequences a ring-oscillator TRNG macro. It warms the macro up,
// samples its output bit at a fixed divider rate and packs the bits into
// words (first bit lands in the MSB). A repetition-count health test runs on
// the bit stream. Finished words are offered on a valid/ready handshake.
module trng_ctrl #(
    parameter int WORD_WIDTH    = 32,
    parameter int WARMUP_CYCLES = 64,
    parameter int SAMPLE_DIV    = 4,
    parameter int REP_LIMIT     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear_err,
    output logic                  trng_en,
    input  logic                  trng_out,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  error_o
);

    localparam int WARM_W = $clog2(WARMUP_CYCLES) + 1;
    localparam int DIV_W  = $clog2(SAMPLE_DIV) + 1;
    localparam int CNT_W  = $clog2(WORD_WIDTH) + 1;
    localparam int REP_W  = $clog2(REP_LIMIT) + 1;

    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(WORD_WIDTH - 1);
    localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);
    localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        COLLECT,
        HOLD,
        ERROR
    } state_t;

    state_t                  state_reg, state_next;
    logic                    bit_q;
    logic [WARM_W-1:0]       warm_reg, warm_next;
    logic [DIV_W-1:0]        div_reg, div_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    // rep_reg == 0 means "no previous sample since warm-up"
    logic [REP_W-1:0]        rep_reg, rep_next;
    logic                    prev_reg, prev_next;
    logic [WORD_WIDTH-1:0]   shreg_reg, shreg_next;
    logic [WORD_WIDTH-1:0]   data_reg, data_next;
    logic                    valid_reg, valid_next;
    logic                    error_reg, error_next;

    logic [WORD_WIDTH-1:0]   shreg_shift;
    logic [REP_W-1:0]        rep_upd;

    // The macro is only powered while it is actually producing bits.
    assign trng_en = (state_reg == WARMUP) || (state_reg == COLLECT);
    assign busy_o  = trng_en;
    assign data_o  = data_reg;
    assign valid_o = valid_reg;
    assign error_o = error_reg;

    // Shifted word and updated repetition count for a sample taken this cycle.
    always_comb begin
        shreg_shift = {shreg_reg[WORD_WIDTH-2:0], bit_q};
        rep_upd     = REP_ONE;
        if (rep_reg != '0 && bit_q == prev_reg) begin
            rep_upd = (rep_reg == REP_MAX) ? rep_reg : rep_reg + REP_ONE;
        end
    end

    // Next-state and datapath decisions for the controller FSM.
    always_comb begin
        state_next = state_reg;
        warm_next  = warm_reg;
        div_next   = div_reg;
        cnt_next   = cnt_reg;
        rep_next   = rep_reg;
        prev_next  = prev_reg;
        shreg_next = shreg_reg;
        data_next  = data_reg;
        valid_next = valid_reg;
        error_next = error_reg;

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = WARMUP;
                    warm_next  = '0;
                end
            end

            WARMUP: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (warm_reg == WARM_LAST) begin
                    state_next = COLLECT;
                    div_next   = '0;
                    cnt_next   = '0;
                    rep_next   = '0;
                end else begin
                    warm_next = warm_reg + WARM_W'(1);
                end
            end

            COLLECT: begin
                if (!enable) begin
                    // Partial word is dropped; bit count restarts next time.
                    state_next = IDLE;
                    div_next   = '0;
                    cnt_next   = '0;
                end else if (div_reg == DIV_LAST) begin
                    div_next   = '0;
                    shreg_next = shreg_shift;
                    prev_next  = bit_q;
                    rep_next   = rep_upd;
                    // A failed health test wins over completing the word.
                    if (rep_upd == REP_MAX) begin
                        state_next = ERROR;
                        error_next = 1'b1;
                        valid_next = 1'b0;
                        cnt_next   = '0;
                    end else if (cnt_reg == WORD_LAST) begin
                        state_next = HOLD;
                        data_next  = shreg_shift;
                        valid_next = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end

            HOLD: begin
                if (valid_reg && ready_i) begin
                    valid_next = 1'b0;
                    if (enable) begin
                        state_next = COLLECT;
                        div_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            ERROR: begin
                if (clear_err) begin
                    state_next = IDLE;
                    error_next = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; the raw TRNG bit is re-registered every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            bit_q     <= 1'b0;
            warm_reg  <= '0;
            div_reg   <= '0;
            cnt_reg   <= '0;
            rep_reg   <= '0;
            prev_reg  <= 1'b0;
            shreg_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            bit_q     <= trng_out;
            warm_reg  <= warm_next;
            div_reg   <= div_next;
            cnt_reg   <= cnt_next;
            rep_reg   <= rep_next;
            prev_reg  <= prev_next;
            shreg_reg <= shreg_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            error_reg <= error_next;
        end
    end

endmodule

// File: tb/tb_trng_ctrl.sv
// Directed testbench for trng_ctrl with WORD_WIDTH=8, WARMUP_CYCLES=4,
// SAMPLE_DIV=2, REP_LIMIT=5. Inputs change 1 time unit after the rising
// edge; outputs are checked at the same point.
module tb_trng_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear_err;
    logic       trng_en;
    logic       trng_out;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       busy_o;
    logic       error_o;

    int nvec = 0;
    int nerr = 0;

    trng_ctrl #(
        .WORD_WIDTH   (8),
        .WARMUP_CYCLES(4),
        .SAMPLE_DIV   (2),
        .REP_LIMIT    (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .clear_err(clear_err),
        .trng_en  (trng_en),
        .trng_out (trng_out),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .busy_o   (busy_o),
        .error_o  (error_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // From IDLE: raise enable, check trng_en over the 4 warm-up cycles,
    // and end on the first COLLECT cycle (div = 0).
    task automatic warm(input string tag);
        enable = 1'b1;
        check({tag, "_en_pre"}, 32'(trng_en), 32'd0);
        tick();
        check({tag, "_en_w0"}, 32'(trng_en), 32'd1);
        check({tag, "_busy_w0"}, 32'(busy_o), 32'd1);
        tick();
        tick();
        tick();
        check({tag, "_en_w3"}, 32'(trng_en), 32'd1);
        tick();
    endtask

    // One sample per two cycles: trng_out held through the div=0 cycle
    // (registered into bit_q) and the div=1 cycle (sampled).
    task automatic send_bits(input string tag, input logic [7:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            trng_out = w[i];
            tick();
            check($sformatf("%s_en_s%0d", tag, i), 32'(trng_en), 32'd1);
            tick();
        end
    endtask

    initial begin
        logic [7:0] w;
        reset     = 1'b1;
        enable    = 1'b0;
        clear_err = 1'b0;
        trng_out  = 1'b0;
        ready_i   = 1'b0;
        tick();
        tick();
        check("rst0_valid", 32'(valid_o), 32'd0);
        check("rst0_en", 32'(trng_en), 32'd0);
        reset = 1'b0;
        tick();

        // Basic word 1,0,1,1,0,0,1,0 -> 8'hB2, held with ready_i low.
        warm("basic");
        w = 8'hB2;
        send_bits("basic", w, 7, 0);
        check("basic_valid", 32'(valid_o), 32'd1);
        check("basic_data", 32'(data_o), 32'hB2);
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("hold_valid_c%0d", c), 32'(valid_o), 32'd1);
            check($sformatf("hold_en_c%0d", c), 32'(trng_en), 32'd0);
        end
        check("hold_data", 32'(data_o), 32'hB2);

        // Handshake with enable high: straight back to COLLECT, no warm-up.
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("hs_valid", 32'(valid_o), 32'd0);
        check("hs_en_nowarm", 32'(trng_en), 32'd1);
        w = 8'h4D;
        send_bits("word2", w, 7, 0);
        check("word2_valid", 32'(valid_o), 32'd1);
        check("word2_data", 32'(data_o), 32'h4D);

        // Handshake with enable low: back to IDLE.
        enable  = 1'b0;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("idle_valid", 32'(valid_o), 32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);

        // Abort after 3 samples, then a full warm-up and a clean 8-bit word.
        warm("abort");
        w = 8'hE0;
        send_bits("abort", w, 7, 5);
        enable = 1'b0;
        tick();
        check("abort_en", 32'(trng_en), 32'd0);
        check("abort_valid", 32'(valid_o), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        warm("rewarm");
        w = 8'hCA;
        send_bits("fresh", w, 7, 3);
        check("fresh_nopartial", 32'(valid_o), 32'd0);
        send_bits("fresh", w, 2, 0);
        check("fresh_valid", 32'(valid_o), 32'd1);
        check("fresh_data", 32'(data_o), 32'hCA);
        enable  = 1'b0;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;

        // Reset for 2 cycles in the middle of COLLECT.
        warm("rstc");
        w = 8'hA0;
        send_bits("rstc", w, 7, 5);
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_en", 32'(trng_en), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_error", 32'(error_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);

        // Health fail: five 1s trip the repetition test on the 5th sample.
        warm("health");
        w = 8'hFF;
        send_bits("health", w, 7, 4);
        check("health_noerr4", 32'(error_o), 32'd0);
        send_bits("health", w, 3, 3);
        check("health_err", 32'(error_o), 32'd1);
        check("health_en", 32'(trng_en), 32'd0);
        check("health_valid", 32'(valid_o), 32'd0);
        check("health_busy", 32'(busy_o), 32'd0);
        enable = 1'b0;
        tick();
        check("err_en_low_err", 32'(error_o), 32'd1);
        enable = 1'b1;
        tick();
        check("err_en_high_err", 32'(error_o), 32'd1);
        check("err_en_high_trng", 32'(trng_en), 32'd0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clr_err", 32'(error_o), 32'd0);
        check("clr_en", 32'(trng_en), 32'd0);

        // Boundary: word 0,1,0,1,0,1,1,1 ends with a run of three 1s; two more
        // 1s in the next word make the run 5 on that word's 2nd sample.
        warm("bnd");
        w = 8'h57;
        send_bits("bnd", w, 7, 0);
        check("bnd_valid", 32'(valid_o), 32'd1);
        check("bnd_data", 32'(data_o), 32'h57);
        check("bnd_noerr", 32'(error_o), 32'd0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("bnd_hs_valid", 32'(valid_o), 32'd0);
        w = 8'hFF;
        send_bits("bnd2", w, 7, 7);
        check("bnd_rep4_noerr", 32'(error_o), 32'd0);
        send_bits("bnd2", w, 6, 6);
        check("bnd_rep5_err", 32'(error_o), 32'd1);
        check("bnd_err_en", 32'(trng_en), 32'd0);
        check("bnd_err_data", 32'(data_o), 32'h57);
        check("bnd_err_valid", 32'(valid_o), 32'd0);
        enable    = 1'b0;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("bnd_clr", 32'(error_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
